// File: rtl/pwm_fade_sequencer.sv
// rtl/pwm_fade_sequencer.sv - level fade sequencer producing committed duty values for three PWM channels
// Ports: clk (rising edge); rst (synchronous, active-low); en (advance sequence);
//        mode (00 off, 01 ramp, 10 breathe, 11 colour cycle); period_end (commit strobe);
//        duty_r/duty_g/duty_b (committed duty, R+1 bits); step_tick (one pulse per level step);
//        state (FSM encoding: IDLE=0 UP=1 HOLD_HI=2 DOWN=3 HOLD_LO=4).
// Build option: PWM_SEQ_GAMMA_EN adds a registered (lvl*lvl)>>R gamma stage.
module pwm_fade_sequencer #(
    parameter int R          = 8,
    parameter int STEP_DIV   = 1250000,
    parameter int HOLD_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       period_end,
    output logic [R:0] duty_r,
    output logic [R:0] duty_g,
    output logic [R:0] duty_b,
    output logic       step_tick,
    output logic [2:0] state
);
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [R:0]    FULL       = {1'b1, {R{1'b0}}};
    localparam logic [R:0]    ONE        = (R+1)'(1);
    localparam logic [1:0]    MODE_OFF    = 2'b00;
    localparam logic [1:0]    MODE_RAMP   = 2'b01;
    localparam logic [1:0]    MODE_BREATH = 2'b10;
    localparam logic [1:0]    MODE_COLOUR = 2'b11;
    localparam logic [1:0]    CH_R = 2'd0;
    localparam logic [1:0]    CH_G = 2'd1;
    localparam logic [1:0]    CH_B = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP      = 3'd1,
        S_HOLD_HI = 3'd2,
        S_DOWN    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    state_t        cur, nxt;
    logic [PW-1:0] presc;
    logic [1:0]    mode_q;
    logic          mode_chg;
    logic [R:0]    lvl, lvl_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [1:0]    chan, chan_n;
    logic [R:0]    f_lvl;
    logic [R:0]    pend_r, pend_g, pend_b;

    assign mode_chg  = (mode != mode_q);
    assign step_tick = rst && en && (presc == PRESC_LAST);
    assign state     = cur;

    always_comb begin
        nxt    = cur;
        lvl_n  = lvl;
        hold_n = hold_cnt;
        chan_n = chan;
        if (mode_chg) begin
            // A new pattern always restarts from a dark, red, idle sequence.
            nxt    = S_IDLE;
            lvl_n  = '0;
            hold_n = '0;
            chan_n = CH_R;
        end else if (step_tick) begin
            case (cur)
                S_IDLE: begin
                    if (mode != MODE_OFF) nxt = S_UP;
                end
                S_UP: begin
                    if (lvl == FULL) begin
                        // Only the ramp pattern sits at full scale in UP; it wraps to dark.
                        lvl_n = '0;
                    end else begin
                        lvl_n = lvl + ONE;
                        if (lvl == FULL - ONE && mode != MODE_RAMP) nxt = S_HOLD_HI;
                    end
                end
                S_HOLD_HI: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_n = '0;
                        nxt    = S_DOWN;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
                S_DOWN: begin
                    if (lvl <= ONE) begin
                        lvl_n = '0;
                        nxt   = S_HOLD_LO;
                    end else begin
                        lvl_n = lvl - ONE;
                    end
                end
                S_HOLD_LO: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_n = '0;
                        nxt    = S_UP;
                        if (mode == MODE_COLOUR) chan_n = (chan == CH_B) ? CH_R : chan + 2'd1;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc    <= '0;
            mode_q   <= MODE_OFF;
            cur      <= S_IDLE;
            lvl      <= '0;
            hold_cnt <= '0;
            chan     <= CH_R;
            duty_r   <= '0;
            duty_g   <= '0;
            duty_b   <= '0;
        end else begin
            mode_q   <= mode;
            cur      <= nxt;
            lvl      <= lvl_n;
            hold_cnt <= hold_n;
            chan     <= chan_n;
            if (mode_chg)       presc <= '0;
            else if (step_tick) presc <= '0;
            else if (en)        presc <= presc + 1'b1;
            // Pending values are sampled before this edge's level update, so a
            // coincident step commits the old level.
            if (period_end) begin
                duty_r <= pend_r;
                duty_g <= pend_g;
                duty_b <= pend_b;
            end
        end
    end

`ifdef PWM_SEQ_GAMMA_EN
    logic [2*R+1:0] lvl_sq;
    assign lvl_sq = {{(R+1){1'b0}}, lvl} * {{(R+1){1'b0}}, lvl};
    always_ff @(posedge clk) begin
        if (!rst) f_lvl <= '0;
        else      f_lvl <= (R+1)'(lvl_sq >> R);
    end
`else
    assign f_lvl = lvl;
`endif

    always_comb begin
        pend_r = '0;
        pend_g = '0;
        pend_b = '0;
        case (mode)
            MODE_RAMP, MODE_BREATH: begin
                pend_r = f_lvl;
                pend_g = f_lvl;
                pend_b = f_lvl;
            end
            MODE_COLOUR: begin
                case (chan)
                    CH_R:    pend_r = f_lvl;
                    CH_G:    pend_g = f_lvl;
                    default: pend_b = f_lvl;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb/tb_pwm_fade_sequencer.sv - self-checking bench for pwm_fade_sequencer
module tb_pwm_fade_sequencer;
    localparam int R  = 4;
    localparam int SD = 4;
    localparam int H  = 2;
    localparam int W  = R + 1;
    localparam int FS = 1 << R;
    localparam int L  = 2 * FS + 2 * H;

    logic         clk = 1'b0;
    logic         rst, en, period_end;
    logic [1:0]   mode;
    logic [R:0]   duty_r, duty_g, duty_b;
    logic         step_tick;
    logic [2:0]   state;

    int checks = 0;
    int failures = 0;

    int m_presc = 0;
    int m_n = 0;
    int m_mode_q = 0;
    int m_gq = 0;
    logic [3*W-1:0] m_duty = '0;

    pwm_fade_sequencer #(.R(R), .STEP_DIV(SD), .HOLD_TICKS(H)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .period_end(period_end),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .step_tick(step_tick), .state(state)
    );

    always #5 clk = ~clk;

    // Sequence position after n level steps since the last restart.
    function automatic int tbl_state(int mq, int n);
        int r;
        if (mq == 0 || n == 0) return 0;
        if (mq == 1) return 1;
        r = (n - 1) % L;
        if (r < FS) return 1;
        if (r < FS + H) return 2;
        if (r < 2 * FS + H) return 3;
        return 4;
    endfunction

    function automatic int tbl_lvl(int mq, int n);
        int r;
        if (mq == 0 || n == 0) return 0;
        if (mq == 1) return (n - 1) % (FS + 1);
        r = (n - 1) % L;
        if (r < FS) return r;
        if (r < FS + H) return FS;
        if (r < 2 * FS + H) return FS - (r - FS - H);
        return 0;
    endfunction

    function automatic int tbl_chan(int mq, int n);
        if (mq != 3 || n == 0) return 0;
        return ((n - 1) / L) % 3;
    endfunction

    function automatic logic [3*W-1:0] pend_of(int md, int fv, int ch);
        logic [W-1:0] v;
        logic [W-1:0] z;
        v = W'(fv);
        z = '0;
        case (md)
            1, 2:    return {v, v, v};
            3:       return (ch == 0) ? {v, z, z} : (ch == 1) ? {z, v, z} : {z, z, v};
            default: return '0;
        endcase
    endfunction

    function automatic logic exp_tick();
        return (rst === 1'b1) && (en === 1'b1) && (m_presc == SD - 1);
    endfunction

    task automatic step(input logic e, input logic [1:0] md, input logic pe, input logic rs);
        logic [3*W-1:0] pend;
        int fv;
        int lv;
        en = e; mode = md; period_end = pe; rst = rs;
        @(posedge clk);
        lv = tbl_lvl(m_mode_q, m_n);
`ifdef PWM_SEQ_GAMMA_EN
        fv = m_gq;
`else
        fv = lv;
`endif
        pend = pend_of(int'(md), fv, tbl_chan(m_mode_q, m_n));
        if (!rs) begin
            m_presc = 0; m_n = 0; m_mode_q = 0; m_gq = 0; m_duty = '0;
        end else begin
            if (pe) m_duty = pend;
            m_gq = (lv * lv) >> R;
            if (int'(md) != m_mode_q) begin
                m_n = 0; m_presc = 0;
            end else if (e) begin
                if (m_presc == SD - 1) begin m_presc = 0; m_n++; end
                else m_presc++;
            end
            m_mode_q = int'(md);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom), 2'($urandom), 1'($urandom), 1'b0);
            checks += 3;
            if ({duty_r, duty_g, duty_b} !== '0) begin failures++; $display("FAIL reset_duty i=%0d got=%h exp=0", i, {duty_r, duty_g, duty_b}); end
            if (state !== 3'd0) begin failures++; $display("FAIL reset_state i=%0d got=%0d exp=0", i, state); end
            if (step_tick !== 1'b0) begin failures++; $display("FAIL reset_tick i=%0d got=%b exp=0", i, step_tick); end
        end
    endtask

    task automatic test_startup();
        int tq[$];
        for (int k = 1; k <= 13; k++) begin
            step(1'b1, 2'b10, 1'b0, 1'b1);
            if (step_tick === 1'b1) tq.push_back(k);
            checks += 2;
            if ({duty_r, duty_g, duty_b} !== '0) begin failures++; $display("FAIL startup_duty k=%0d got=%h exp=0", k, {duty_r, duty_g, duty_b}); end
            if (state !== 3'(tbl_state(m_mode_q, m_n))) begin failures++; $display("FAIL startup_state k=%0d got=%0d exp=%0d", k, state, tbl_state(m_mode_q, m_n)); end
        end
        checks++;
        if (tq.size() < 3) begin
            failures++; $display("FAIL startup_tick_count got=%0d exp>=3", tq.size());
        end else begin
            checks += 2;
            if (tq[0] != 4) begin failures++; $display("FAIL startup_first_tick got=%0d exp=4", tq[0]); end
            if (tq[1] != 8 || tq[2] != 12) begin failures++; $display("FAIL startup_tick_spacing got=%0d,%0d exp=8,12", tq[1], tq[2]); end
        end
    endtask

    task automatic test_breathe();
        int seq[$];
        int exp_seq[$] = '{0, 1, 2, 3, 4, 1, 2, 3, 4, 1};
        step(1'b1, 2'b00, 1'b1, 1'b1);
        step(1'b1, 2'b00, 1'b1, 1'b1);
        seq.push_back(int'(state));
        for (int i = 0; i < 310; i++) begin
            step(1'b1, 2'b10, 1'b1, 1'b1);
            if (int'(state) != seq[$]) seq.push_back(int'(state));
            checks += 3;
            if ({duty_r, duty_g, duty_b} !== m_duty) begin failures++; $display("FAIL breathe_duty i=%0d got=%h exp=%h", i, {duty_r, duty_g, duty_b}, m_duty); end
            if (state !== 3'(tbl_state(m_mode_q, m_n))) begin failures++; $display("FAIL breathe_state i=%0d got=%0d exp=%0d", i, state, tbl_state(m_mode_q, m_n)); end
            if (step_tick !== exp_tick()) begin failures++; $display("FAIL breathe_tick i=%0d got=%b exp=%b", i, step_tick, exp_tick()); end
        end
        checks++;
        if (seq != exp_seq) begin failures++; $display("FAIL breathe_state_order got_len=%0d exp_len=%0d", seq.size(), exp_seq.size()); end
    endtask

    task automatic test_colour();
        int act[$];
        int exp_act[$] = '{0, 1, 2, 0};
        int a;
        step(1'b1, 2'b00, 1'b1, 1'b1);
        step(1'b1, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 470; i++) begin
            step(1'b1, 2'b11, 1'b1, 1'b1);
            a = (duty_r != 0) ? 0 : (duty_g != 0) ? 1 : (duty_b != 0) ? 2 : -1;
            if (a >= 0 && (act.size() == 0 || act[$] != a)) act.push_back(a);
            checks += 3;
            if ({duty_r, duty_g, duty_b} !== m_duty) begin failures++; $display("FAIL colour_duty i=%0d got=%h exp=%h", i, {duty_r, duty_g, duty_b}, m_duty); end
            if (state !== 3'(tbl_state(m_mode_q, m_n))) begin failures++; $display("FAIL colour_state i=%0d got=%0d exp=%0d", i, state, tbl_state(m_mode_q, m_n)); end
            if (int'(duty_r != 0) + int'(duty_g != 0) + int'(duty_b != 0) > 1) begin failures++; $display("FAIL colour_exclusive i=%0d got=%h exp=one_channel", i, {duty_r, duty_g, duty_b}); end
        end
        checks++;
        if (act != exp_act) begin failures++; $display("FAIL colour_channel_order got_len=%0d exp_len=4", act.size()); end
    endtask

    task automatic test_ramp();
        logic [3*W-1:0] prev;
        logic pe;
        step(1'b1, 2'b01, 1'b0, 1'b1);
        for (int i = 0; i < 250; i++) begin
            prev = {duty_r, duty_g, duty_b};
            pe = (i % 10 == 9);
            step(($urandom_range(0, 4) != 0), 2'b01, pe, 1'b1);
            checks += 4;
            if ({duty_r, duty_g, duty_b} !== m_duty) begin failures++; $display("FAIL ramp_duty i=%0d got=%h exp=%h", i, {duty_r, duty_g, duty_b}, m_duty); end
            if (state !== 3'(tbl_state(m_mode_q, m_n))) begin failures++; $display("FAIL ramp_state i=%0d got=%0d exp=%0d", i, state, tbl_state(m_mode_q, m_n)); end
            if (step_tick !== exp_tick()) begin failures++; $display("FAIL ramp_tick i=%0d got=%b exp=%b", i, step_tick, exp_tick()); end
            if (!pe && {duty_r, duty_g, duty_b} !== prev) begin failures++; $display("FAIL ramp_hold i=%0d got=%h exp=%h", i, {duty_r, duty_g, duty_b}, prev); end
        end
    endtask

    task automatic test_mode_change();
        bit found = 0;
        int first = -1;
        step(1'b1, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b1, 2'b10, 1'b1, 1'b1);
            if (tbl_state(m_mode_q, m_n) == 3 && tbl_lvl(m_mode_q, m_n) == 9) found = 1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL modechg_reach_down9 got=timeout exp=found"); end
        step(1'b1, 2'b01, 1'b1, 1'b1);
        checks += 2;
        if (state !== 3'd0) begin failures++; $display("FAIL modechg_idle got=%0d exp=0", state); end
        if ({duty_r, duty_g, duty_b} !== {5'd9, 5'd9, 5'd9}) begin failures++; $display("FAIL modechg_commit_old got=%h exp=%h", {duty_r, duty_g, duty_b}, {5'd9, 5'd9, 5'd9}); end
        for (int k = 2; k <= 8; k++) begin
            step(1'b1, 2'b01, 1'b1, 1'b1);
            if (k == 2) begin
                checks++;
                if ({duty_r, duty_g, duty_b} !== '0) begin failures++; $display("FAIL modechg_lvl_zero got=%h exp=0", {duty_r, duty_g, duty_b}); end
            end
            if (step_tick === 1'b1 && first < 0) first = k;
        end
        checks++;
        if (first != 4) begin failures++; $display("FAIL modechg_presc_clear got=%0d exp=4", first); end
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b1, 2'b01, 1'b1, 1'b1);
            if (tbl_state(m_mode_q, m_n) == 1 && tbl_lvl(m_mode_q, m_n) >= 3) found = 1;
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rstmid_reach_up got=timeout exp=found"); end
        step(1'b1, 2'b01, 1'b1, 1'b0);
        checks += 3;
        if ({duty_r, duty_g, duty_b} !== '0) begin failures++; $display("FAIL rstmid_duty got=%h exp=0", {duty_r, duty_g, duty_b}); end
        if (state !== 3'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", state); end
        if (step_tick !== 1'b0) begin failures++; $display("FAIL rstmid_tick got=%b exp=0", step_tick); end
    endtask

    task automatic test_random();
        logic [1:0] md;
        md = 2'b10;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 49) == 0) md = 2'($urandom);
            step(($urandom_range(0, 3) != 0), md, ($urandom_range(0, 9) < 3), ($urandom_range(0, 199) != 0));
            checks += 3;
            if ({duty_r, duty_g, duty_b} !== m_duty) begin failures++; $display("FAIL random_duty i=%0d got=%h exp=%h", i, {duty_r, duty_g, duty_b}, m_duty); end
            if (state !== 3'(tbl_state(m_mode_q, m_n))) begin failures++; $display("FAIL random_state i=%0d got=%0d exp=%0d", i, state, tbl_state(m_mode_q, m_n)); end
            if (step_tick !== exp_tick()) begin failures++; $display("FAIL random_tick i=%0d got=%b exp=%b", i, step_tick, exp_tick()); end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = 2'b00; period_end = 1'b0;
        @(negedge clk);
        test_reset();
        test_startup();
        test_breathe();
        test_colour();
        test_ramp();
        test_mode_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
